// File: rtl/mips_pkg.sv
// mips_pkg: shared constants for the multicycle MIPS control unit.
//   - opcode / funct encodings of the supported instruction subset
//   - ALU control codes, alu_src_b and pc_src mux encodings
//   - control FSM state enum (binary, 4 bits) and ALU decode class enum
package mips_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_J     = 6'h02;

   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_SLT = 6'h2A;

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_SLT = 3'b111;

   localparam logic [1:0] SRCB_B       = 2'b00;
   localparam logic [1:0] SRCB_FOUR    = 2'b01;
   localparam logic [1:0] SRCB_IMM     = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADR  = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_EXEC    = 4'd6,
      S_ALUWB   = 4'd7,
      S_BRANCH  = 4'd8,
      S_ADDIEX  = 4'd9,
      S_ADDIWB  = 4'd10,
      S_JUMP    = 4'd11,
      S_ILLEGAL = 4'd12
   } state_t;

   // What the ALU is asked to do in the current state.
   typedef enum logic [1:0] {
      ACLS_ADD   = 2'd0,
      ACLS_SUB   = 2'd1,
      ACLS_FUNCT = 2'd2
   } alu_cls_t;

endpackage

// File: rtl/mips_alu_dec.sv
// mips_alu_dec: combinational ALU control decoder.
//   alu_cls  : in  2  ALU class requested by the FSM (add / sub / from funct)
//   funct    : in  6  IR[5:0]
//   alu_ctrl : out 3  ALU control code
//   funct_ok : out 1  funct is a supported R-type function (always 1 outside
//                     the funct class)
module mips_alu_dec
   import mips_pkg::*;
(
   input  logic [1:0] alu_cls,
   input  logic [5:0] funct,
   output logic [2:0] alu_ctrl,
   output logic       funct_ok
);

   always_comb begin
      alu_ctrl = ALU_ADD;
      funct_ok = 1'b1;
      case (alu_cls_t'(alu_cls))
         ACLS_SUB: alu_ctrl = ALU_SUB;
         ACLS_FUNCT: begin
            case (funct)
               FN_ADD:  alu_ctrl = ALU_ADD;
               FN_SUB:  alu_ctrl = ALU_SUB;
               FN_AND:  alu_ctrl = ALU_AND;
               FN_OR:   alu_ctrl = ALU_OR;
               FN_SLT:  alu_ctrl = ALU_SLT;
               default: funct_ok = 1'b0;
            endcase
         end
         default: alu_ctrl = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/mips_mc_ctrl.sv
// mips_mc_ctrl: multicycle control FSM for the lab MIPS core.
//   clk, rst (async, active low)
//   opcode, funct      : in   IR fields
//   zero, mem_rdy      : in   ALU zero flag, memory access done this cycle
//   pc_we, iord, mem_re, mem_we, ir_we, reg_dst, mem_to_reg, rf_we,
//   alu_src_a, alu_src_b, alu_ctrl, pc_src : out  datapath controls
//   instr_done         : out  pulse in the final state of each instruction
//   illegal            : out  sticky unsupported-instruction flag
module mips_mc_ctrl
   import mips_pkg::*;
#(
   parameter int unsigned ALU_W = 3
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic [5:0]       opcode,
   input  logic [5:0]       funct,
   input  logic             zero,
   input  logic             mem_rdy,
   output logic             pc_we,
   output logic             iord,
   output logic             mem_re,
   output logic             mem_we,
   output logic             ir_we,
   output logic             reg_dst,
   output logic             mem_to_reg,
   output logic             rf_we,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [ALU_W-1:0] alu_ctrl,
   output logic [1:0]       pc_src,
   output logic             instr_done,
   output logic             illegal
);

   state_t     state_q, state_d;
   logic       illegal_q;
   alu_cls_t   alu_cls;
   logic [2:0] alu_code;
   logic       funct_ok;

   // ALU class depends on state only, kept apart from the main decode so the
   // funct_ok feedback into next-state logic is not a combinational loop.
   always_comb begin
      alu_cls = ACLS_ADD;
      if (state_q == S_EXEC)
         alu_cls = ACLS_FUNCT;
      else if (state_q == S_BRANCH)
         alu_cls = ACLS_SUB;
   end

   mips_alu_dec u_alu_dec (
      .alu_cls  (alu_cls),
      .funct    (funct),
      .alu_ctrl (alu_code),
      .funct_ok (funct_ok)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_FETCH;
         illegal_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_d == S_ILLEGAL)
            illegal_q <= 1'b1;
      end
   end

   always_comb begin
      state_d    = state_q;
      pc_we      = 1'b0;
      iord       = 1'b0;
      mem_re     = 1'b0;
      mem_we     = 1'b0;
      ir_we      = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      rf_we      = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = SRCB_B;
      alu_ctrl   = ALU_W'(alu_code);
      pc_src     = PCSRC_ALU;
      instr_done = 1'b0;

      case (state_q)
         S_FETCH: begin
            mem_re    = 1'b1;
            alu_src_b = SRCB_FOUR;
            if (mem_rdy) begin
               ir_we   = 1'b1;
               pc_we   = 1'b1;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            alu_src_b = SRCB_IMM_SH2;
            case (opcode)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYPE:     state_d = S_EXEC;
               OP_BEQ:       state_d = S_BRANCH;
               OP_ADDI:      state_d = S_ADDIEX;
               OP_J:         state_d = S_JUMP;
               default:      state_d = S_ILLEGAL;
            endcase
         end
         S_MEMADR: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
            state_d   = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
         end
         S_MEMRD: begin
            mem_re = 1'b1;
            iord   = 1'b1;
            if (mem_rdy)
               state_d = S_MEMWB;
         end
         S_MEMWB: begin
            rf_we      = 1'b1;
            mem_to_reg = 1'b1;
            instr_done = 1'b1;
            state_d    = S_FETCH;
         end
         S_MEMWR: begin
            mem_we = 1'b1;
            iord   = 1'b1;
            if (mem_rdy) begin
               instr_done = 1'b1;
               state_d    = S_FETCH;
            end
         end
         S_EXEC: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_B;
            state_d   = funct_ok ? S_ALUWB : S_ILLEGAL;
         end
         S_ALUWB: begin
            rf_we      = 1'b1;
            reg_dst    = 1'b1;
            instr_done = 1'b1;
            state_d    = S_FETCH;
         end
         S_BRANCH: begin
            alu_src_a  = 1'b1;
            alu_src_b  = SRCB_B;
            pc_src     = PCSRC_ALUOUT;
            pc_we      = zero;
            instr_done = 1'b1;
            state_d    = S_FETCH;
         end
         S_ADDIEX: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
            state_d   = S_ADDIWB;
         end
         S_ADDIWB: begin
            rf_we      = 1'b1;
            instr_done = 1'b1;
            state_d    = S_FETCH;
         end
         S_JUMP: begin
            pc_src     = PCSRC_JUMP;
            pc_we      = 1'b1;
            instr_done = 1'b1;
            state_d    = S_FETCH;
         end
         S_ILLEGAL: state_d = S_ILLEGAL;
         default:   state_d = S_FETCH;
      endcase

      // Reset is asynchronous: outputs must drop the moment rst goes low,
      // not at the next edge, so a pending memory access is aborted.
      if (!rst) begin
         pc_we      = 1'b0;
         iord       = 1'b0;
         mem_re     = 1'b0;
         mem_we     = 1'b0;
         ir_we      = 1'b0;
         reg_dst    = 1'b0;
         mem_to_reg = 1'b0;
         rf_we      = 1'b0;
         alu_src_a  = 1'b0;
         alu_src_b  = '0;
         alu_ctrl   = '0;
         pc_src     = '0;
         instr_done = 1'b0;
      end
   end

   assign illegal = illegal_q;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// tb_mips_mc_ctrl: self-checking bench for mips_mc_ctrl. Each instruction is
// expanded into a list of control steps (with planned memory wait cycles),
// and the DUT outputs are compared every cycle against the step's expected
// controls; fields the step leaves unspecified are masked off.
module tb_mips_mc_ctrl;

   typedef struct packed {
      logic       pc_we;
      logic       iord;
      logic       mem_re;
      logic       mem_we;
      logic       ir_we;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       rf_we;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [2:0] alu_ctrl;
      logic [1:0] pc_src;
      logic       instr_done;
      logic       illegal;
   } outs_t;

   typedef enum {
      PH_FETCH, PH_DECODE, PH_MEMADR, PH_MEMRD, PH_MEMWB, PH_MEMWR, PH_EXEC,
      PH_ALUWB, PH_BRANCH, PH_ADDIEX, PH_ADDIWB, PH_JUMP, PH_ILLEGAL
   } phase_t;

   typedef struct {
      phase_t ph;
      logic   rdy;
   } step_t;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [5:0] opcode = '0;
   logic [5:0] funct = '0;
   logic       zero = 1'b0;
   logic       mem_rdy = 1'b0;
   logic       pc_we, iord, mem_re, mem_we, ir_we, reg_dst, mem_to_reg, rf_we;
   logic       alu_src_a, instr_done, illegal;
   logic [1:0] alu_src_b, pc_src;
   logic [2:0] alu_ctrl;

   outs_t      got;
   step_t      plan[$];
   int         n_checks = 0;
   int         n_errors = 0;

   assign got = {pc_we, iord, mem_re, mem_we, ir_we, reg_dst, mem_to_reg,
                 rf_we, alu_src_a, alu_src_b, alu_ctrl, pc_src, instr_done,
                 illegal};

   always #5 clk = ~clk;

   mips_mc_ctrl #(.ALU_W(3)) dut (
      .clk        (clk),
      .rst        (rst),
      .opcode     (opcode),
      .funct      (funct),
      .zero       (zero),
      .mem_rdy    (mem_rdy),
      .pc_we      (pc_we),
      .iord       (iord),
      .mem_re     (mem_re),
      .mem_we     (mem_we),
      .ir_we      (ir_we),
      .reg_dst    (reg_dst),
      .mem_to_reg (mem_to_reg),
      .rf_we      (rf_we),
      .alu_src_a  (alu_src_a),
      .alu_src_b  (alu_src_b),
      .alu_ctrl   (alu_ctrl),
      .pc_src     (pc_src),
      .instr_done (instr_done),
      .illegal    (illegal)
   );

   task automatic check(input string tag, input logic [31:0] got_v,
                        input logic [31:0] exp_v);
      n_checks++;
      if (got_v !== exp_v) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got_v, exp_v);
      end
   endtask

   function automatic logic rbit();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic logic [2:0] ref_alu(input logic [5:0] f, output logic ok);
      ok = 1'b1;
      case (f)
         6'h20:   return 3'b010;
         6'h22:   return 3'b110;
         6'h24:   return 3'b000;
         6'h25:   return 3'b001;
         6'h2A:   return 3'b111;
         default: begin ok = 1'b0; return 3'b000; end
      endcase
   endfunction

   function automatic bit is_legal_op(input logic [5:0] op);
      return op == 6'h00 || op == 6'h23 || op == 6'h2B || op == 6'h04 ||
             op == 6'h08 || op == 6'h02;
   endfunction

   // Zero-wait cycle count per instruction.
   function automatic int cpi(input logic [5:0] op);
      case (op)
         6'h23:   return 5;
         6'h2B:   return 4;
         6'h00:   return 4;
         6'h08:   return 4;
         6'h04:   return 3;
         6'h02:   return 3;
         default: return 0;
      endcase
   endfunction

   function automatic void expect_for(input phase_t ph, input logic rdy,
                                      output outs_t e, output outs_t m);
      logic       ok;
      logic [2:0] code;
      e = '0;
      m = '0;
      // Enables and status are always checked; selects only where they matter.
      m.pc_we = 1'b1; m.mem_re = 1'b1; m.mem_we = 1'b1; m.ir_we = 1'b1;
      m.rf_we = 1'b1; m.instr_done = 1'b1; m.illegal = 1'b1;
      case (ph)
         PH_FETCH: begin
            e.mem_re = 1'b1; m.iord = 1'b1; m.alu_src_a = 1'b1;
            e.alu_src_b = 2'b01; m.alu_src_b = '1;
            e.alu_ctrl = 3'b010; m.alu_ctrl = '1; m.pc_src = '1;
            e.ir_we = rdy; e.pc_we = rdy;
         end
         PH_DECODE: begin
            m.alu_src_a = 1'b1; e.alu_src_b = 2'b11; m.alu_src_b = '1;
            e.alu_ctrl = 3'b010; m.alu_ctrl = '1;
         end
         PH_MEMADR, PH_ADDIEX: begin
            e.alu_src_a = 1'b1; m.alu_src_a = 1'b1;
            e.alu_src_b = 2'b10; m.alu_src_b = '1;
            e.alu_ctrl = 3'b010; m.alu_ctrl = '1;
         end
         PH_MEMRD: begin
            e.mem_re = 1'b1; e.iord = 1'b1; m.iord = 1'b1;
         end
         PH_MEMWB: begin
            e.rf_we = 1'b1; e.mem_to_reg = 1'b1; m.mem_to_reg = 1'b1;
            m.reg_dst = 1'b1; e.instr_done = 1'b1;
         end
         PH_MEMWR: begin
            e.mem_we = 1'b1; e.iord = 1'b1; m.iord = 1'b1;
            e.instr_done = rdy;
         end
         PH_EXEC: begin
            e.alu_src_a = 1'b1; m.alu_src_a = 1'b1; m.alu_src_b = '1;
            code = ref_alu(funct, ok);
            if (ok) begin
               e.alu_ctrl = code; m.alu_ctrl = '1;
            end
         end
         PH_ALUWB: begin
            e.rf_we = 1'b1; e.reg_dst = 1'b1; m.reg_dst = 1'b1;
            m.mem_to_reg = 1'b1; e.instr_done = 1'b1;
         end
         PH_BRANCH: begin
            e.alu_src_a = 1'b1; m.alu_src_a = 1'b1; m.alu_src_b = '1;
            e.alu_ctrl = 3'b110; m.alu_ctrl = '1;
            e.pc_src = 2'b01; m.pc_src = '1;
            e.pc_we = zero; e.instr_done = 1'b1;
         end
         PH_ADDIWB: begin
            e.rf_we = 1'b1; m.reg_dst = 1'b1; m.mem_to_reg = 1'b1;
            e.instr_done = 1'b1;
         end
         PH_JUMP: begin
            e.pc_src = 2'b10; m.pc_src = '1; e.pc_we = 1'b1;
            e.instr_done = 1'b1;
         end
         PH_ILLEGAL: e.illegal = 1'b1;
         default: ;
      endcase
   endfunction

   task automatic build_plan(input logic [5:0] op, input logic [5:0] fn,
                             input int unsigned wf, input int unsigned wm);
      logic ok;
      logic [2:0] unused_code;
      plan.delete();
      repeat (wf) plan.push_back('{PH_FETCH, 1'b0});
      plan.push_back('{PH_FETCH, 1'b1});
      plan.push_back('{PH_DECODE, rbit()});
      case (op)
         6'h23: begin
            plan.push_back('{PH_MEMADR, rbit()});
            repeat (wm) plan.push_back('{PH_MEMRD, 1'b0});
            plan.push_back('{PH_MEMRD, 1'b1});
            plan.push_back('{PH_MEMWB, rbit()});
         end
         6'h2B: begin
            plan.push_back('{PH_MEMADR, rbit()});
            repeat (wm) plan.push_back('{PH_MEMWR, 1'b0});
            plan.push_back('{PH_MEMWR, 1'b1});
         end
         6'h00: begin
            plan.push_back('{PH_EXEC, rbit()});
            unused_code = ref_alu(fn, ok);
            if (ok) plan.push_back('{PH_ALUWB, rbit()});
            else repeat (5) plan.push_back('{PH_ILLEGAL, rbit()});
         end
         6'h04: plan.push_back('{PH_BRANCH, rbit()});
         6'h08: begin
            plan.push_back('{PH_ADDIEX, rbit()});
            plan.push_back('{PH_ADDIWB, rbit()});
         end
         6'h02: plan.push_back('{PH_JUMP, rbit()});
         default: repeat (20) plan.push_back('{PH_ILLEGAL, rbit()});
      endcase
   endtask

   // Walks the plan one cycle per step; returns the 1-based cycle of the
   // first instr_done pulse (0 if none) and the number of pulses seen.
   task automatic exec_plan(input string tag, input logic [5:0] op,
                            input logic [5:0] fn, input logic z,
                            output int done_at, output int dones);
      outs_t e, m;
      done_at = 0;
      dones = 0;
      foreach (plan[i]) begin
         @(negedge clk);
         if (i == 0) begin
            opcode = op; funct = fn; zero = z;
         end
         mem_rdy = plan[i].rdy;
         #1;
         expect_for(plan[i].ph, plan[i].rdy, e, m);
         check($sformatf("%s[%0d]", tag, i), 32'(got & m), 32'(e & m));
         if (instr_done === 1'b1) begin
            dones++;
            if (done_at == 0) done_at = i + 1;
         end
      end
   endtask

   task automatic run_instr(input string tag, input logic [5:0] op,
                            input logic [5:0] fn, input logic z,
                            input int unsigned wf, input int unsigned wm);
      int unsigned wm_eff;
      int done_at, dones;
      logic ok;
      logic [2:0] unused_code;
      wm_eff = (op == 6'h23 || op == 6'h2B) ? wm : 0;
      build_plan(op, fn, wf, wm_eff);
      exec_plan(tag, op, fn, z, done_at, dones);
      unused_code = ref_alu(fn, ok);
      if (is_legal_op(op) && (op != 6'h00 || ok)) begin
         check({tag, ".cycles"}, 32'(done_at), 32'(cpi(op) + int'(wf + wm_eff)));
         check({tag, ".ndone"}, 32'(dones), 32'd1);
      end
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      rst = 1'b0;
      mem_rdy = 1'b1;
      #1;
      check({tag, ".zero_out"}, 32'(got), 32'd0);
      @(posedge clk);
      #1;
      check({tag, ".held"}, 32'(got), 32'd0);
      #1;
      rst = 1'b1;
      mem_rdy = 1'b0;
   endtask

   initial begin : main
      logic [5:0] ops[6];
      logic [5:0] fns[5];
      logic [5:0] op, bad;
      int done_at, dones;
      ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h02};
      fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};

      do_reset("reset");

      run_instr("r_add", 6'h00, 6'h20, 1'b0, 0, 0);
      run_instr("lw_w2", 6'h23, 6'h00, 1'b0, 0, 2);
      run_instr("beq_z1", 6'h04, 6'h00, 1'b1, 0, 0);
      run_instr("beq_z0", 6'h04, 6'h00, 1'b0, 0, 0);
      run_instr("sw_w3", 6'h2B, 6'h00, 1'b0, 0, 3);
      run_instr("fetch_w2", 6'h08, 6'h00, 1'b0, 2, 0);

      run_instr("op3f", 6'h3F, 6'h00, 1'b0, 0, 0);
      do_reset("op3f.rst");
      run_instr("after_ill", 6'h02, 6'h00, 1'b0, 0, 0);

      // Reset while a store is stalled: mem_we must fall without an edge.
      build_plan(6'h2B, 6'h00, 0, 3);
      void'(plan.pop_back());
      void'(plan.pop_back());
      exec_plan("sw_abort", 6'h2B, 6'h00, 1'b0, done_at, dones);
      @(negedge clk);
      mem_rdy = 1'b0;
      #1;
      check("abort.pre_we", 32'(mem_we), 32'd1);
      #2;
      rst = 1'b0;
      #1;
      check("abort.mem_we", 32'(mem_we), 32'd0);
      check("abort.all", 32'(got), 32'd0);
      @(posedge clk);
      #2;
      rst = 1'b1;
      run_instr("after_abort", 6'h23, 6'h00, 1'b0, 1, 1);

      for (int n = 0; n < 60; n++) begin
         op = ops[$urandom_range(0, 5)];
         run_instr($sformatf("rnd%0d_op%0h", n, op), op,
                   fns[$urandom_range(0, 4)], rbit(),
                   $urandom_range(0, 3), $urandom_range(0, 3));
      end

      run_instr("bad_funct", 6'h00, 6'h3F, 1'b0, 0, 0);
      do_reset("bad_funct.rst");

      bad = 6'h3F;
      while (is_legal_op(bad)) bad = 6'($urandom_range(0, 63));
      for (int n = 0; n < 4; n++) begin
         bad = 6'($urandom_range(0, 63));
         while (is_legal_op(bad)) bad = 6'($urandom_range(0, 63));
         run_instr($sformatf("badop_%0h", bad), bad, 6'h20, 1'b0,
                   $urandom_range(0, 2), 0);
         do_reset("badop.rst");
         run_instr("badop.recover", 6'h00, 6'h2A, 1'b0, 0, 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "time limit");
   end

endmodule

// File: doc/mips_mc_ctrl.md
# mips_mc_ctrl

Multicycle control unit for the lab MIPS core. It sequences a shared-memory multicycle datapath (PC, IR, register file, ALU, single instruction/data memory) one step per clock, with a memory wait-state handshake. It replaces the single-cycle combinational control inside `mips_top` and emits every datapath enable and mux select.

## Interface
Parameters:
- `ALU_W`, default 3: width of the ALU control code.

Ports (clock and reset first):
- `clk`, input, 1: rising-edge clock.
- `rst`, input, 1: asynchronous, active-low reset.
- `opcode`, input, 6: IR[31:26].
- `funct`, input, 6: IR[5:0].
- `zero`, input, 1: ALU zero flag.
- `mem_rdy`, input, 1: memory access completes this cycle.
- `pc_we`, output, 1: PC write enable.
- `iord`, output, 1: memory address select (0 = PC, 1 = ALUOut).
- `mem_re` / `mem_we`, output, 1 each: memory read / write request.
- `ir_we`, output, 1: IR write enable.
- `reg_dst`, output, 1: 1 = rd, 0 = rt.
- `mem_to_reg`, output, 1: 1 = MDR, 0 = ALUOut.
- `rf_we`, output, 1: register file write enable.
- `alu_src_a`, output, 1: 0 = PC, 1 = A.
- `alu_src_b`, output, 2: 00 = B, 01 = 4, 10 = sign-extended immediate, 11 = immediate << 2.
- `alu_ctrl`, output, ALU_W: 010 add, 110 sub, 000 and, 001 or, 111 slt.
- `pc_src`, output, 2: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `instr_done`, output, 1: one-cycle pulse in the final state of each instruction.
- `illegal`, output, 1: sticky flag for an unsupported opcode.

## Operation
- Supported instructions: R-type (op 0x00; funct add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A), lw 0x23, sw 0x2B, beq 0x04, addi 0x08, j 0x02.
- Reset: state FETCH; all outputs 0; `illegal` = 0. Outputs are a function of state, plus `mem_rdy`/`zero` where noted.
- FETCH: `mem_re`=1, `iord`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_ctrl`=add, `pc_src`=00.
  - `ir_we` and `pc_we` assert only when `mem_rdy`=1; the next state is then DECODE.
  - Otherwise the FSM stays in FETCH.
- DECODE: `alu_src_b`=11, add (branch target to ALUOut). Next state by opcode:
  - lw/sw -> MEMADR
  - R -> EXEC
  - beq -> BRANCH
  - addi -> ADDIEX
  - j -> JUMP
  - anything else -> ILLEGAL
- MEMADR: `alu_src_a`=1, `alu_src_b`=10, add. Next MEMRD (lw) or MEMWR (sw).
- MEMRD: `mem_re`=1, `iord`=1. On `mem_rdy` go to MEMWB, else hold.
- MEMWB: `rf_we`=1, `mem_to_reg`=1, `reg_dst`=0, `instr_done`=1. Next FETCH.
- MEMWR: `mem_we`=1, `iord`=1. On `mem_rdy`: `instr_done`=1 and go to FETCH; else hold. `mem_we` stays high for the whole wait.
- EXEC: `alu_src_a`=1, `alu_src_b`=00, `alu_ctrl` from funct. An unknown funct raises `illegal` and goes to ILLEGAL. Next ALUWB.
- ALUWB: `rf_we`=1, `reg_dst`=1, `mem_to_reg`=0, `instr_done`=1. Next FETCH.
- BRANCH: `alu_src_a`=1, `alu_src_b`=00, sub, `pc_src`=01, `pc_we`=`zero`, `instr_done`=1. Next FETCH.
- ADDIEX: `alu_src_a`=1, `alu_src_b`=10, add. Next ADDIWB.
- ADDIWB: `rf_we`=1, `reg_dst`=0, `mem_to_reg`=0, `instr_done`=1. Next FETCH.
- JUMP: `pc_src`=10, `pc_we`=1, `instr_done`=1. Next FETCH.
- ILLEGAL: all enables 0 and `illegal`=1. The state is absorbing until `rst` is asserted.

## Timing
- Cycles per instruction with zero wait states: lw 5, sw 4, R 4, addi 4, beq 3, j 3.
- Each wait cycle (`mem_rdy`=0) in FETCH, MEMRD or MEMWR adds exactly 1 cycle.
- State register and `illegal` update on the rising edge of `clk`. Asserting `rst` mid-instruction forces FETCH and zero outputs immediately, without waiting for a clock edge. This aborts any pending memory access.
- `rf_we`, `mem_we` and `pc_we` never assert together.

## Structure
- Package `mips_pkg` holds the opcode and funct constants, the ALU codes, the `alu_src_b`/`pc_src` encodings and the state enum (binary encoded, 4 bits).
- Sub-module `mips_alu_dec` is combinational: (state class, funct) -> `alu_ctrl` plus an `funct_ok` flag. The FSM and output decode stay in `mips_mc_ctrl`.

## Test plan
- Reset, then R-type add (funct 0x20) with `mem_rdy`=1 -> FETCH, DECODE, EXEC (`alu_ctrl`=010), ALUWB (`rf_we`=1, `reg_dst`=1). `instr_done` pulses on cycle 4.
- lw with `mem_rdy` held low for 2 cycles in MEMRD -> 7 total cycles. `mem_re` and `iord` are high throughout MEMRD. `rf_we` and `mem_to_reg` are high only in MEMWB.
- beq with `zero`=1, then with `zero`=0 -> `pc_we`=1 with `pc_src`=01 in BRANCH, then `pc_we`=0. Both take 3 cycles.
- sw with `mem_rdy`=0 for 3 cycles -> `mem_we` high for 4 consecutive cycles. `rf_we` never asserts.
- opcode 0x3F -> ILLEGAL after DECODE, `illegal`=1, no enables for 20 cycles. Asserting `rst` low clears `illegal` and returns the FSM to FETCH.
- `rst` asserted during MEMWR wait -> `mem_we` drops to 0 without a clock edge. After release the FSM restarts in FETCH.
